// File: rtl/cpu_seq_ctrl_if.sv
// Sequencer <-> datapath/memory control bundle.
// The master modport is the sequencer side; the slave modport is the datapath/memory side.
interface cpu_seq_ctrl_if;
  logic       run;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ack;
  logic       ir_load;
  logic       pc_inc;
  logic       pc_branch;
  logic [2:0] alu_ctrl;
  logic       alusrc;
  logic       radr2_sel;
  logic       memtoreg;
  logic       reg_write;
  logic       mem_req;
  logic       mem_we;
  logic       busy;
  logic       halted;

  modport master (
    input  run, opcode, zero, mem_ack,
    output ir_load, pc_inc, pc_branch, alu_ctrl, alusrc, radr2_sel, memtoreg,
           reg_write, mem_req, mem_we, busy, halted
  );

  modport slave (
    output run, opcode, zero, mem_ack,
    input  ir_load, pc_inc, pc_branch, alu_ctrl, alusrc, radr2_sel, memtoreg,
           reg_write, mem_req, mem_we, busy, halted
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit CPU datapath.
// Define SEQ_PERF_EN to add the saturating instret/stall_cnt performance counters.
module cpu_seq_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic           clk,
  input  logic           rst,
  cpu_seq_ctrl_if.master bus
`ifdef SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be nonzero");
  end

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalted} state_e;
  typedef enum logic [2:0] {KindAlu, KindLw, KindSw, KindBeq, KindNop} kind_e;

  state_e     state_q, state_d;
  kind_e      kind_q, kind_dec;
  logic [2:0] alu_ctrl_q, alu_dec;
  logic       alusrc_q, alusrc_dec;
  logic       radr2_sel_q, radr2_dec;
  logic       memtoreg_q, memtoreg_dec;
  logic       mem_we_q, mem_we_dec;
  logic       ctrl_load, retire;
  logic       ir_load, pc_inc, pc_branch, reg_write, mem_req, halted;

  always_comb begin
    kind_dec     = KindNop;
    alu_dec      = 3'b000;
    alusrc_dec   = 1'b0;
    radr2_dec    = 1'b0;
    memtoreg_dec = 1'b0;
    mem_we_dec   = 1'b0;
    if (!bus.opcode[3]) begin
      kind_dec = KindAlu;
      alu_dec  = bus.opcode[2:0];
    end else begin
      case (bus.opcode[2:0])
        3'd0: begin
          kind_dec   = KindAlu;
          alusrc_dec = 1'b1;
        end
        3'd1: begin
          kind_dec     = KindLw;
          alusrc_dec   = 1'b1;
          memtoreg_dec = 1'b1;
        end
        3'd2: begin
          kind_dec   = KindSw;
          alusrc_dec = 1'b1;
          radr2_dec  = 1'b1;
          mem_we_dec = 1'b1;
        end
        3'd3: begin
          kind_dec  = KindBeq;
          alu_dec   = 3'b001;
          radr2_dec = 1'b1;
        end
        default: kind_dec = KindNop;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    ctrl_load = 1'b0;
    retire    = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    reg_write = 1'b0;
    mem_req   = 1'b0;
    halted    = 1'b0;
    case (state_q)
      StIdle: if (bus.run) state_d = StFetch;
      StFetch: begin
        ir_load = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        if (bus.opcode == HALT_OP) begin
          state_d = StHalted;
        end else begin
          ctrl_load = 1'b1;
          state_d   = StExec;
        end
      end
      StExec: begin
        case (kind_q)
          KindAlu:        state_d = StWb;
          KindLw, KindSw: state_d = StMem;
          KindBeq: begin
            pc_branch = bus.zero;
            pc_inc    = ~bus.zero;
            retire    = 1'b1;
          end
          default: begin
            pc_inc = 1'b1;
            retire = 1'b1;
          end
        endcase
      end
      StMem: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          if (kind_q == KindSw) begin
            pc_inc = 1'b1;
            retire = 1'b1;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        reg_write = 1'b1;
        pc_inc    = 1'b1;
        retire    = 1'b1;
      end
      StHalted: halted = 1'b1;
      default:  state_d = StIdle;
    endcase
    // run is only consulted at instruction boundaries, so dropping it never aborts
    if (retire) state_d = bus.run ? StFetch : StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      kind_q      <= KindNop;
      alu_ctrl_q  <= 3'b000;
      alusrc_q    <= 1'b0;
      radr2_sel_q <= 1'b0;
      memtoreg_q  <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ctrl_load) begin
        kind_q      <= kind_dec;
        alu_ctrl_q  <= alu_dec;
        alusrc_q    <= alusrc_dec;
        radr2_sel_q <= radr2_dec;
        memtoreg_q  <= memtoreg_dec;
        mem_we_q    <= mem_we_dec;
      end
    end
  end

  assign bus.ir_load   = ir_load;
  assign bus.pc_inc    = pc_inc;
  assign bus.pc_branch = pc_branch;
  assign bus.reg_write = reg_write;
  assign bus.mem_req   = mem_req;
  assign bus.halted    = halted;
  assign bus.busy      = (state_q != StIdle) && (state_q != StHalted);
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.alusrc    = alusrc_q;
  assign bus.radr2_sel = radr2_sel_q;
  assign bus.memtoreg  = memtoreg_q;
  assign bus.mem_we    = mem_we_q;

`ifdef SEQ_PERF_EN
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] instret_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
      stall_q   <= '0;
    end else begin
      if (retire && (instret_q != '1)) instret_q <= instret_q + CntOne;
      if ((state_q == StMem) && !bus.mem_ack && (stall_q != '1)) stall_q <= stall_q + CntOne;
    end
  end

  assign instret   = instret_q;
  assign stall_cnt = stall_q;
`endif

endmodule
